// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding and default operand width.
package mul_seq_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Issue/result handshake bundle between the execute stage, the multiplier and writeback.
interface mul_seq_ctrl_if #(parameter int WIDTH = 8);

    logic                   start_valid;
    logic                   start_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   result_valid;
    logic                   result_ready;
    logic [2*WIDTH-1:0]     product;

    modport slave (
        input  start_valid, a, b, result_ready,
        output start_ready, busy, result_valid, product
    );

    modport master (
        output start_valid, a, b, result_ready,
        input  start_ready, busy, result_valid, product
    );

endinterface

// File: rtl/full_adder_8bit.sv
// 8-bit ripple-carry adder used as the single step adder of the multiplier.
// Purely combinational; no handshake.
module full_adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[8];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Shift-add multiplier: one WIDTH-bit add per cycle, result WIDTH clocks after accept.
// One op in flight; result_ready low holds the product in DONE indefinitely.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    mul_seq_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_accept;
    logic               w_step;
    logic               w_last;

    assign w_accept = (r_state == ST_IDLE) && bus.start_valid;
    assign w_step   = (r_state == ST_RUN);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_addend = r_mplier[0] ? r_mcand : '0;

    generate
        if (WIDTH == 8) begin : g_fa8
            full_adder_8bit u_add (
                .a    (r_acc_hi),
                .b    (w_addend),
                .cin  (1'b0),
                .sum  (w_sum),
                .cout (w_cout)
            );
        end else begin : g_beh
            assign {w_cout, w_sum} = {1'b0, r_acc_hi} + {1'b0, w_addend};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)           w_state_nxt = ST_DONE;
            ST_DONE: if (bus.result_ready) w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    // The adder carry becomes the MSB shifted into acc_hi, so nothing is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_acc_hi <= {w_cout, w_sum[WIDTH-1:1]};
            r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.start_ready  = (r_state == ST_IDLE);
    assign bus.busy         = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign bus.result_valid = (r_state == ST_DONE);
    assign bus.product      = {r_acc_hi, r_acc_lo};

endmodule
